// File: rtl/board_state_keeper_if.sv
// Move link between the selection stage, the remote rx link, the tx link and board_state_keeper.
// master = environment side, slave = board_state_keeper side.
interface board_state_keeper_if;
   logic        moved;
   logic [11:0] move_packet;
   logic        rx_valid;
   logic [11:0] rx_packet;
   logic        rx_ready;
   logic        tx_valid;
   logic [11:0] tx_packet;
   logic        tx_ready;

   modport master (
      output moved, move_packet, rx_valid, rx_packet, tx_ready,
      input  rx_ready, tx_valid, tx_packet
   );

   modport slave (
      input  moved, move_packet, rx_valid, rx_packet, tx_ready,
      output rx_ready, tx_valid, tx_packet
   );
endinterface

// File: rtl/board_state_keeper.sv
// Authoritative 8x8 board: applies local and remote moves, forwards local moves to the tx link.
// Optional AUTO_PROMOTE_EN: pawns reaching the last rank are written as queens.
module board_state_keeper #(
   parameter logic [3:0]  EMPTY_CODE   = 4'd15,
   parameter logic        FIRST_PLAYER = 1'b1,
   parameter int unsigned TX_TIMEOUT   = 50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   player,
   input  logic                   new_game,
   board_state_keeper_if.slave    link,
   output logic [7:0][7:0][3:0]   stable_board,
   output logic                   curr_player,
   output logic                   capture_valid,
   output logic [3:0]             captured_piece,
   output logic [7:0]             move_count,
   output logic                   err
);

   localparam int unsigned CNT_W = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, APPLY, SEND} state_t;

   state_t               state_q, state_d;
   logic [11:0]          pkt_q, pkt_d;
   logic                 local_q, local_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0][7:0][3:0] board_d;
   logic                 curr_d, cap_valid_d, err_d, rx_ready_d, tx_valid_d;
   logic [3:0]           cap_piece_d;
   logic [7:0]           count_d;
   logic [11:0]          tx_packet_d;

   logic [2:0] ox, oy, nx, ny;
   logic [3:0] src_piece, dst_piece, placed_piece;
   logic       mover, reject;

   // Opening layout: player 0 on rows 0-1, player 1 on rows 6-7.
   function automatic logic [7:0][7:0][3:0] start_layout();
      logic [7:0][7:0][3:0] b;
      logic [3:0]           kind;
      b = {64{EMPTY_CODE}};
      for (int x = 0; x < 8; x++) begin
         case (x)
            0, 7:    kind = 4'd3;
            1, 6:    kind = 4'd1;
            2, 5:    kind = 4'd2;
            3:       kind = 4'd4;
            default: kind = 4'd5;
         endcase
         b[0][x] = kind + 4'd6;
         b[1][x] = 4'd6;
         b[6][x] = 4'd0;
         b[7][x] = kind;
      end
      return b;
   endfunction

   assign ox        = pkt_q[11:9];
   assign oy        = pkt_q[8:6];
   assign nx        = pkt_q[5:3];
   assign ny        = pkt_q[2:0];
   assign src_piece = stable_board[oy][ox];
   assign dst_piece = stable_board[ny][nx];
   assign mover     = local_q ? player : ~player;

   // Codes 0-5 belong to player 1, codes 6-11 to player 0.
   assign reject = (src_piece == EMPTY_CODE)
                 || ((src_piece >= 4'd12) && (src_piece <= 4'd14))
                 || (pkt_q[11:6] == pkt_q[5:0])
                 || ((src_piece < 4'd6) != mover);

   always_comb begin
      placed_piece = src_piece;
`ifdef AUTO_PROMOTE_EN
      if (src_piece == 4'd0 && ny == 3'd0)
         placed_piece = 4'd4;
      else if (src_piece == 4'd6 && ny == 3'd7)
         placed_piece = 4'd10;
`endif
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      local_d     = local_q;
      cnt_d       = cnt_q;
      board_d     = stable_board;
      curr_d      = curr_player;
      cap_valid_d = 1'b0;
      cap_piece_d = captured_piece;
      count_d     = move_count;
      err_d       = 1'b0;
      tx_valid_d  = link.tx_valid;
      tx_packet_d = link.tx_packet;

      if (new_game) begin
         board_d    = start_layout();
         curr_d     = FIRST_PLAYER;
         count_d    = 8'd0;
         tx_valid_d = 1'b0;
         cnt_d      = '0;
         state_d    = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (link.moved && curr_player == player) begin
                  pkt_d   = link.move_packet;
                  local_d = 1'b1;
                  state_d = APPLY;
               end else begin
                  if (link.moved)
                     err_d = 1'b1;
                  if (link.rx_valid && link.rx_ready) begin
                     pkt_d   = link.rx_packet;
                     local_d = 1'b0;
                     state_d = APPLY;
                  end
               end
            end
            APPLY: begin
               if (link.moved)
                  err_d = 1'b1;
               if (reject) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  board_d[ny][nx] = placed_piece;
                  board_d[oy][ox] = EMPTY_CODE;
                  curr_d          = ~curr_player;
                  if (move_count != 8'hFF)
                     count_d = move_count + 8'd1;
                  if (dst_piece != EMPTY_CODE) begin
                     cap_valid_d = 1'b1;
                     cap_piece_d = dst_piece;
                  end
                  if (local_q) begin
                     tx_valid_d  = 1'b1;
                     tx_packet_d = pkt_q;
                     cnt_d       = '0;
                     state_d     = SEND;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            SEND: begin
               if (link.moved)
                  err_d = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (link.tx_ready) begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end else if (cnt_q == CNT_W'(TX_TIMEOUT - 1)) begin
                  tx_valid_d = 1'b0;
                  err_d      = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      rx_ready_d = (state_d == IDLE) && (curr_d != player);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         pkt_q          <= 12'd0;
         local_q        <= 1'b0;
         cnt_q          <= '0;
         stable_board   <= {64{EMPTY_CODE}};
         curr_player    <= 1'b0;
         capture_valid  <= 1'b0;
         captured_piece <= EMPTY_CODE;
         move_count     <= 8'd0;
         err            <= 1'b0;
         link.rx_ready  <= 1'b0;
         link.tx_valid  <= 1'b0;
         link.tx_packet <= 12'd0;
      end else begin
         state_q        <= state_d;
         pkt_q          <= pkt_d;
         local_q        <= local_d;
         cnt_q          <= cnt_d;
         stable_board   <= board_d;
         curr_player    <= curr_d;
         capture_valid  <= cap_valid_d;
         captured_piece <= cap_piece_d;
         move_count     <= count_d;
         err            <= err_d;
         link.rx_ready  <= rx_ready_d;
         link.tx_valid  <= tx_valid_d;
         link.tx_packet <= tx_packet_d;
      end
   end

endmodule

// File: tb/tb_board_state_keeper.sv
// Scoreboard bench for board_state_keeper: chess-rule reference model, directed cases, random moves.
module tb_board_state_keeper;

   localparam int   TXTO   = 6;
   localparam logic PLAYER = 1'b1;
   localparam int   EMPTY  = 15;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic player = PLAYER;
   logic new_game = 1'b0;
   logic [7:0][7:0][3:0] stable_board;
   logic curr_player, capture_valid, err;
   logic [3:0] captured_piece;
   logic [7:0] move_count;

   board_state_keeper_if link();

   board_state_keeper #(.TX_TIMEOUT(TXTO)) dut (
      .clk(clk), .reset_n(reset_n), .player(player), .new_game(new_game), .link(link),
      .stable_board(stable_board), .curr_player(curr_player), .capture_valid(capture_valid),
      .captured_piece(captured_piece), .move_count(move_count), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int m_board[8][8];
   int m_curr, m_count, m_last_cap, m_applied;
   int exp_cap[$];
   int exp_err[$];
   logic [11:0] exp_tx[$];
   bit mon_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] pk(input int ox, input int oy, input int nx, input int ny);
      return {3'(ox), 3'(oy), 3'(nx), 3'(ny)};
   endfunction

   function automatic int colour(input int code);
      return (code < 6) ? 1 : 0;
   endfunction

   function automatic int count_colour(input int c);
      int n = 0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            if (m_board[y][x] != EMPTY && m_board[y][x] < 12 && colour(m_board[y][x]) == c) n++;
      return n;
   endfunction

   task automatic model_new_game();
      int back[8];
      back = '{3, 1, 2, 4, 5, 2, 1, 3};
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++) m_board[y][x] = EMPTY;
      for (int x = 0; x < 8; x++) begin
         m_board[0][x] = back[x] + 6;
         m_board[1][x] = 6;
         m_board[6][x] = 0;
         m_board[7][x] = back[x];
      end
      m_curr  = 1;
      m_count = 0;
   endtask

   // Chess-rule view of one move; queues the pulses the DUT should produce.
   task automatic model_apply(input logic [11:0] pkt, input bit is_local, output bit ok);
      int ox, oy, nx, ny, p, d, mv;
      ox = int'(pkt[11:9]); oy = int'(pkt[8:6]); nx = int'(pkt[5:3]); ny = int'(pkt[2:0]);
      p  = m_board[oy][ox];
      d  = m_board[ny][nx];
      mv = is_local ? int'(PLAYER) : 1 - int'(PLAYER);
      if (p == EMPTY || p >= 12 || (ox == nx && oy == ny) || colour(p) != mv) begin
         exp_err.push_back(1);
         ok = 1'b0;
         return;
      end
`ifdef AUTO_PROMOTE_EN
      if (p == 0 && ny == 0) p = 4;
      if (p == 6 && ny == 7) p = 10;
`endif
      m_board[ny][nx] = p;
      m_board[oy][ox] = EMPTY;
      m_curr = 1 - m_curr;
      m_applied++;
      if (m_count < 255) m_count++;
      if (d != EMPTY) begin
         exp_cap.push_back(d);
         m_last_cap = d;
      end
      ok = 1'b1;
   endtask

   task automatic check_state(input string tag);
      int diffs = 0;
      @(negedge clk);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            if (int'(stable_board[y][x]) != m_board[y][x]) diffs++;
      check({tag, ".board_diffs"}, diffs, 0);
      check({tag, ".curr_player"}, int'(curr_player), m_curr);
      check({tag, ".move_count"}, int'(move_count), m_count);
      check({tag, ".captured_piece"}, int'(captured_piece), m_last_cap);
      check({tag, ".rx_ready"}, int'(link.rx_ready), int'(m_curr != int'(PLAYER)));
      check({tag, ".tx_valid_idle"}, int'(link.tx_valid), 0);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mon_on && reset_n) begin
            if (capture_valid) begin
               check("capture_pending", int'(exp_cap.size() > 0), 1);
               if (exp_cap.size() > 0) check("captured_piece", int'(captured_piece), exp_cap.pop_front());
            end
            if (err) begin
               check("err_pending", int'(exp_err.size() > 0), 1);
               if (exp_err.size() > 0) void'(exp_err.pop_front());
            end
            if (link.tx_valid && link.tx_ready) begin
               check("tx_pending", int'(exp_tx.size() > 0), 1);
               if (exp_tx.size() > 0) check("tx_packet", int'(link.tx_packet), int'(exp_tx.pop_front()));
            end
         end
      end
   endtask

   task automatic do_new_game();
      tick(); new_game = 1'b1;
      tick(); new_game = 1'b0;
      model_new_game();
      check_state("new_game");
   endtask

   // delay < 0: never assert tx_ready (timeout path, with a stray moved during SEND).
   task automatic do_local(input logic [11:0] pkt, input int delay);
      bit ours, ok;
      int high;
      ours = (m_curr == int'(PLAYER));
      tick(); link.moved = 1'b1; link.move_packet = pkt;
      tick(); link.moved = 1'b0;
      if (!ours) begin
         exp_err.push_back(1);
         repeat (2) tick();
         check_state("local_not_turn");
         return;
      end
      model_apply(pkt, 1'b1, ok);
      @(negedge clk);
      check("tx_latency_n1", int'(link.tx_valid), 0);
      if (!ok) begin
         repeat (2) tick();
         check_state("local_reject");
         return;
      end
      @(negedge clk);
      check("tx_latency_n2", int'(link.tx_valid), 1);
      check("curr_at_n2", int'(curr_player), m_curr);
      if (delay >= 0) begin
         exp_tx.push_back(pkt);
         for (int i = 0; i < delay; i++) begin
            tick();
            @(negedge clk);
            check("tx_hold", int'({link.tx_valid, link.tx_packet}), int'({1'b1, pkt}));
         end
         tick(); link.tx_ready = 1'b1;
         tick(); link.tx_ready = 1'b0;
      end else begin
         exp_err.push_back(1);
         exp_err.push_back(1);
         high = 1;
         tick(); link.moved = 1'b1;
         @(negedge clk);
         if (link.tx_valid) high++;
         tick(); link.moved = 1'b0;
         for (int i = 0; i < TXTO + 5; i++) begin
            @(negedge clk);
            if (!link.tx_valid) break;
            high++;
         end
         check("tx_timeout_cycles", high, TXTO);
      end
      tick();
      check_state("local_done");
   endtask

   task automatic do_remote(input logic [11:0] pkt);
      bit got, ok;
      got = 1'b0;
      tick(); link.rx_valid = 1'b1; link.rx_packet = pkt;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         got = link.rx_ready;
      end
      check("rx_ready_seen", int'(got), 1);
      tick(); link.rx_valid = 1'b0;
      if (got) model_apply(pkt, 1'b0, ok);
      repeat (2) tick();
      check_state("remote_done");
   endtask

   task automatic pick_move(input int mv, output logic [11:0] pkt);
      int sx, sy, dx, dy, code;
      sx = $urandom_range(0, 7); sy = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 9) begin
         for (int t = 0; t < 64; t++) begin
            code = m_board[sy][sx];
            if (code != EMPTY && code < 12 && colour(code) == mv) break;
            sx = $urandom_range(0, 7); sy = $urandom_range(0, 7);
         end
      end
      dx = sx; dy = sy;
      for (int t = 0; t < 30; t++) begin
         dx = $urandom_range(0, 7); dy = $urandom_range(0, 7);
         code = m_board[dy][dx];
         if (dx == sx && dy == sy) continue;
         if (code == EMPTY) break;
         if (count_colour(colour(code)) > 4 && $urandom_range(0, 3) == 0) break;
      end
      pkt = pk(sx, sy, dx, dy);
   endtask

   initial begin
      logic [11:0] pkt;
      int diffs;
      link.moved = 1'b0; link.move_packet = 12'd0;
      link.rx_valid = 1'b0; link.rx_packet = 12'd0; link.tx_ready = 1'b0;
      m_last_cap = EMPTY; m_applied = 0;

      // Reset values.
      @(negedge clk);
      diffs = 0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            if (int'(stable_board[y][x]) != EMPTY) diffs++;
      check("rst.board_diffs", diffs, 0);
      check("rst.curr_player", int'(curr_player), 0);
      check("rst.move_count", int'(move_count), 0);
      check("rst.captured_piece", int'(captured_piece), EMPTY);
      check("rst.rx_ready", int'(link.rx_ready), 0);
      check("rst.tx_valid", int'(link.tx_valid), 0);
      check("rst.tx_packet", int'(link.tx_packet), 0);
      check("rst.err", int'(err), 0);
      check("rst.capture_valid", int'(capture_valid), 0);
      tick(); reset_n = 1'b1;
      mon_on = 1'b1;
      fork monitor(); join_none

      do_new_game();
      check("ng.b64", int'(stable_board[6][4]), 0);
      check("ng.b74", int'(stable_board[7][4]), 5);
      check("ng.b30", int'(stable_board[3][0]), EMPTY);
      check("ng.b03", int'(stable_board[0][3]), 10);
      check("ng.b04", int'(stable_board[0][4]), 11);

      do_local(pk(4, 6, 4, 4), 2);
      do_remote(pk(3, 1, 3, 3));
      do_local(pk(0, 6, 0, 5), 0);
      do_remote(pk(3, 3, 4, 4));
      do_local(pk(2, 2, 2, 3), 0);
      do_local(pk(5, 6, 5, 6), 0);
      do_local(pk(1, 1, 1, 2), 0);
      do_local(pk(7, 6, 7, 5), -1);
      do_local(pk(7, 5, 7, 4), 0);

      for (int n = 0; n < 420; n++) begin
         if (m_curr == int'(PLAYER)) begin
            pick_move(int'(PLAYER), pkt);
            do_local(pkt, $urandom_range(0, 3));
         end else if ($urandom_range(0, 9) == 0) begin
            do_local(12'($urandom), 0);
         end else begin
            pick_move(1 - int'(PLAYER), pkt);
            do_remote(pkt);
         end
      end
      if (m_applied > 255) check("move_count_saturated", int'(move_count), 255);

      repeat (4) tick();
      check("cap_queue_left", exp_cap.size(), 0);
      check("err_queue_left", exp_err.size(), 0);
      check("tx_queue_left", exp_tx.size(), 0);

      // Reset in the middle of SEND drops the packet.
      do_new_game();
      mon_on = 1'b0;
      tick(); link.moved = 1'b1; link.move_packet = pk(4, 6, 4, 4);
      tick(); link.moved = 1'b0;
      repeat (2) @(negedge clk);
      check("send_before_reset", int'(link.tx_valid), 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_mid_send.tx_valid", int'(link.tx_valid), 0);
      check("rst_mid_send.move_count", int'(move_count), 0);
      check("rst_mid_send.b44", int'(stable_board[4][4]), EMPTY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
